ifft4_design: RTL and testbench

//  4-point radix-2 inverse FFT, the return path of the 4-point forward FFT core.

---
 rtl/ifft4_design.sv | 233 +++++++++++++++++++++++
 tb/tb_ifft4_design.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifft4_design.sv
// ----------------------------------------------------------------------------
// ifft4_design
//   4-point radix-2 inverse FFT: x[n] = 1/4 * sum_k X[k] * (+j)^(k*n).
//   A single complex add/sub butterfly is time-shared over four cycles
//   (S1A, S1B, S2A, S2B), followed by a scale/saturate/output cycle (OUT).
//   Samples are packed {re, im}, each component DW-bit signed.
//
//   Build option:
//     IFFT_ROUND_EN  - when defined, round half up (+2 before >>>2) in OUT;
//                      when undefined, plain arithmetic >>>2 (floor).
//   Saturation to the DW-bit signed range is present in both builds.
// ----------------------------------------------------------------------------
module ifft4_design #(
    parameter int DW = 16
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic            new_f,
    input  logic [2*DW-1:0] freq0,
    input  logic [2*DW-1:0] freq1,
    input  logic [2*DW-1:0] freq2,
    input  logic [2*DW-1:0] freq3,
    output logic [2*DW-1:0] pt0,
    output logic [2*DW-1:0] pt1,
    output logic [2*DW-1:0] pt2,
    output logic [2*DW-1:0] pt3,
    output logic            busy,
    output logic            done
);

    // Two growth bits cover the sum of four DW-bit operands.
    localparam int EW = DW + 2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S1A  = 3'd1;
    localparam logic [2:0] ST_S1B  = 3'd2;
    localparam logic [2:0] ST_S2A  = 3'd3;
    localparam logic [2:0] ST_S2B  = 3'd4;
    localparam logic [2:0] ST_OUT  = 3'd5;

    localparam logic signed [EW:0] SAT_MAX = (EW+1)'((2**(DW-1)) - 1);
    localparam logic signed [EW:0] SAT_MIN = (EW+1)'(-(2**(DW-1)));

    // Real half of a packed {re, im} sample.
    function automatic logic [DW-1:0] part_re(input logic [2*DW-1:0] v);
        part_re = v[2*DW-1:DW];
    endfunction

    // Imaginary half of a packed {re, im} sample.
    function automatic logic [DW-1:0] part_im(input logic [2*DW-1:0] v);
        part_im = v[DW-1:0];
    endfunction

    // Sign-extend a DW-bit component to the datapath width.
    function automatic logic signed [EW-1:0] sx(input logic [DW-1:0] v);
        sx = {{(EW-DW){v[DW-1]}}, v};
    endfunction

    // Divide by four (optionally rounding half up) and clamp to DW bits.
    function automatic logic [DW-1:0] scale_sat(input logic signed [EW-1:0] v);
        logic signed [EW:0] t;
        logic signed [EW:0] sh;
`ifdef IFFT_ROUND_EN
        t = {v[EW-1], v} + (EW+1)'(2);
`else
        t = {v[EW-1], v};
`endif
        sh = t >>> 2;
        if (sh > SAT_MAX) begin
            scale_sat = SAT_MAX[DW-1:0];
        end else if (sh < SAT_MIN) begin
            scale_sat = SAT_MIN[DW-1:0];
        end else begin
            scale_sat = sh[DW-1:0];
        end
    endfunction

    logic [2:0]            state_r;
    logic                  busy_r;
    logic                  done_r;
    logic [2*DW-1:0]       x0_r, x1_r, x2_r, x3_r;
    logic [2*DW-1:0]       pt0_r, pt1_r, pt2_r, pt3_r;
    logic signed [EW-1:0]  a0_re_r, a0_im_r, a1_re_r, a1_im_r;
    logic signed [EW-1:0]  b0_re_r, b0_im_r, b1_re_r, b1_im_r;
    logic signed [EW-1:0]  y0_re_r, y0_im_r, y1_re_r, y1_im_r;
    logic signed [EW-1:0]  y2_re_r, y2_im_r, y3_re_r, y3_im_r;

    logic signed [EW-1:0]  op_a_re_s, op_a_im_s, op_b_re_s, op_b_im_s;
    logic signed [EW-1:0]  sum_re_s, sum_im_s, dif_re_s, dif_im_s;

    // Steer the shared butterfly operands according to the current stage.
    always_comb begin
        op_a_re_s = {EW{1'b0}};
        op_a_im_s = {EW{1'b0}};
        op_b_re_s = {EW{1'b0}};
        op_b_im_s = {EW{1'b0}};
        case (state_r)
            ST_S1A: begin
                op_a_re_s = sx(part_re(x0_r));
                op_a_im_s = sx(part_im(x0_r));
                op_b_re_s = sx(part_re(x2_r));
                op_b_im_s = sx(part_im(x2_r));
            end
            ST_S1B: begin
                op_a_re_s = sx(part_re(x1_r));
                op_a_im_s = sx(part_im(x1_r));
                op_b_re_s = sx(part_re(x3_r));
                op_b_im_s = sx(part_im(x3_r));
            end
            ST_S2A: begin
                op_a_re_s = a0_re_r;
                op_a_im_s = a0_im_r;
                op_b_re_s = b0_re_r;
                op_b_im_s = b0_im_r;
            end
            ST_S2B: begin
                op_a_re_s = a1_re_r;
                op_a_im_s = a1_im_r;
                op_b_re_s = b1_re_r;
                op_b_im_s = b1_im_r;
            end
            default: begin
                op_a_re_s = {EW{1'b0}};
                op_a_im_s = {EW{1'b0}};
                op_b_re_s = {EW{1'b0}};
                op_b_im_s = {EW{1'b0}};
            end
        endcase
    end

    assign sum_re_s = op_a_re_s + op_b_re_s;
    assign sum_im_s = op_a_im_s + op_b_im_s;
    assign dif_re_s = op_a_re_s - op_b_re_s;
    assign dif_im_s = op_a_im_s - op_b_im_s;

    // Frame sequencer: capture, four butterfly stages, then scale and publish.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            x0_r    <= {(2*DW){1'b0}};
            x1_r    <= {(2*DW){1'b0}};
            x2_r    <= {(2*DW){1'b0}};
            x3_r    <= {(2*DW){1'b0}};
            pt0_r   <= {(2*DW){1'b0}};
            pt1_r   <= {(2*DW){1'b0}};
            pt2_r   <= {(2*DW){1'b0}};
            pt3_r   <= {(2*DW){1'b0}};
            a0_re_r <= {EW{1'b0}};
            a0_im_r <= {EW{1'b0}};
            a1_re_r <= {EW{1'b0}};
            a1_im_r <= {EW{1'b0}};
            b0_re_r <= {EW{1'b0}};
            b0_im_r <= {EW{1'b0}};
            b1_re_r <= {EW{1'b0}};
            b1_im_r <= {EW{1'b0}};
            y0_re_r <= {EW{1'b0}};
            y0_im_r <= {EW{1'b0}};
            y1_re_r <= {EW{1'b0}};
            y1_im_r <= {EW{1'b0}};
            y2_re_r <= {EW{1'b0}};
            y2_im_r <= {EW{1'b0}};
            y3_re_r <= {EW{1'b0}};
            y3_im_r <= {EW{1'b0}};
        end else begin
            // done is a single-cycle pulse; only OUT raises it.
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (new_f) begin
                        x0_r    <= freq0;
                        x1_r    <= freq1;
                        x2_r    <= freq2;
                        x3_r    <= freq3;
                        busy_r  <= 1'b1;
                        state_r <= ST_S1A;
                    end
                end
                ST_S1A: begin
                    a0_re_r <= sum_re_s;
                    a0_im_r <= sum_im_s;
                    a1_re_r <= dif_re_s;
                    a1_im_r <= dif_im_s;
                    state_r <= ST_S1B;
                end
                ST_S1B: begin
                    b0_re_r <= sum_re_s;
                    b0_im_r <= sum_im_s;
                    // +j * (r, i) = (-i, r)
                    b1_re_r <= -dif_im_s;
                    b1_im_r <= dif_re_s;
                    state_r <= ST_S2A;
                end
                ST_S2A: begin
                    y0_re_r <= sum_re_s;
                    y0_im_r <= sum_im_s;
                    y2_re_r <= dif_re_s;
                    y2_im_r <= dif_im_s;
                    state_r <= ST_S2B;
                end
                ST_S2B: begin
                    y1_re_r <= sum_re_s;
                    y1_im_r <= sum_im_s;
                    y3_re_r <= dif_re_s;
                    y3_im_r <= dif_im_s;
                    state_r <= ST_OUT;
                end
                ST_OUT: begin
                    pt0_r   <= {scale_sat(y0_re_r), scale_sat(y0_im_r)};
                    pt1_r   <= {scale_sat(y1_re_r), scale_sat(y1_im_r)};
                    pt2_r   <= {scale_sat(y2_re_r), scale_sat(y2_im_r)};
                    pt3_r   <= {scale_sat(y3_re_r), scale_sat(y3_im_r)};
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pt0  = pt0_r;
    assign pt1  = pt1_r;
    assign pt2  = pt2_r;
    assign pt3  = pt3_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_ifft4_design.sv
// ----------------------------------------------------------------------------
// tb_ifft4_design
//   Scoreboard bench for ifft4_design (DW = 16). The driver pushes the
//   expected frame result (computed directly from the inverse DFT sum) and
//   the edge at which done must appear; a negedge monitor checks busy, done
//   timing and the held pt0..pt3 values every cycle.
// ----------------------------------------------------------------------------
module tb_ifft4_design;

    localparam int DW = 16;

    typedef struct {
        logic [127:0] pt;
        int           done_edge;
    } exp_t;

    logic            clk_in;
    logic            reset;
    logic            new_f;
    logic [2*DW-1:0] freq0, freq1, freq2, freq3;
    logic [2*DW-1:0] pt0, pt1, pt2, pt3;
    logic            busy;
    logic            done;

    int           n_tests  = 0;
    int           n_fail   = 0;
    int           edge_cnt = 0;
    int           last_acc = -100;
    exp_t         q[$];
    logic [127:0] exp_pt   = 128'd0;
    int           mon_d;
    exp_t         mon_e;

    ifft4_design #(.DW(DW)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .new_f  (new_f),
        .freq0  (freq0),
        .freq1  (freq1),
        .freq2  (freq2),
        .freq3  (freq3),
        .pt0    (pt0),
        .pt1    (pt1),
        .pt2    (pt2),
        .pt3    (pt3),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, expv);
        end
    endtask

    // Divide by four (floor, or round half up) and clamp to 16-bit signed.
    function automatic logic [15:0] scale_ref(input int v);
        int t;
        t = v;
`ifdef IFFT_ROUND_EN
        t = t + 2;
`endif
        t = t >>> 2;
        if (t > 32767) t = 32767;
        else if (t < -32768) t = -32768;
        return 16'(t);
    endfunction

    // x[n] = 1/4 * sum_k X[k] * j^(k*n), returned packed {x0, x1, x2, x3}.
    function automatic logic [127:0] ref_ifft(input logic [31:0] f0, input logic [31:0] f1,
                                              input logic [31:0] f2, input logic [31:0] f3);
        logic [31:0]  f [4];
        logic [127:0] r;
        int xr, xi, sr, si;
        f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
        r = 128'd0;
        for (int n = 0; n < 4; n++) begin
            sr = 0;
            si = 0;
            for (int k = 0; k < 4; k++) begin
                xr = int'($signed(f[k][31:16]));
                xi = int'($signed(f[k][15:0]));
                case ((k * n) % 4)
                    0: begin sr = sr + xr; si = si + xi; end
                    1: begin sr = sr - xi; si = si + xr; end
                    2: begin sr = sr - xr; si = si - xi; end
                    3: begin sr = sr + xi; si = si - xr; end
                    default: begin sr = sr; si = si; end
                endcase
            end
            r[(3-n)*32 +: 32] = {scale_ref(sr), scale_ref(si)};
        end
        return r;
    endfunction

    function automatic logic [31:0] c(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    function automatic int rcomp();
        case ($urandom_range(0, 3))
            0:       return -32768;
            1:       return 32767;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    function automatic logic [31:0] rbin();
        return c(rcomp(), rcomp());
    endfunction

    // Drive one cycle; model acceptance as "no frame in the last 6 edges".
    task automatic step(input logic nf, input logic [31:0] f0, input logic [31:0] f1,
                        input logic [31:0] f2, input logic [31:0] f3);
        exp_t e;
        @(negedge clk_in);
        #1;
        new_f = nf;
        freq0 = f0; freq1 = f1; freq2 = f2; freq3 = f3;
        if (nf && (edge_cnt + 1 - last_acc >= 6)) begin
            e.pt        = ref_ifft(f0, f1, f2, f3);
            e.done_edge = edge_cnt + 1 + 5;
            q.push_back(e);
            last_acc    = edge_cnt + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rbin(), rbin(), rbin(), rbin());
    endtask

    // Monitor: busy every cycle, done against the scoreboard, pt held values.
    always @(negedge clk_in) begin
        if (reset) exp_pt = 128'd0;
        mon_d = edge_cnt - last_acc;
        check("busy", 128'(busy), 128'((mon_d >= 0 && mon_d <= 4) ? 1 : 0));
        if (!done && q.size() > 0 && q[0].done_edge <= edge_cnt) begin
            mon_e = q.pop_front();
            check("done_missing", 128'(done), 128'd1);
            exp_pt = mon_e.pt;
        end else if (done) begin
            if (q.size() == 0) begin
                check("done_unexpected", 128'(done), 128'd0);
            end else begin
                mon_e = q.pop_front();
                check("done_latency", 128'(edge_cnt), 128'(mon_e.done_edge));
                exp_pt = mon_e.pt;
            end
        end
        check("pt", {pt0, pt1, pt2, pt3}, exp_pt);
    end

    initial begin
        reset = 1'b0;
        new_f = 1'b0;
        freq0 = 32'd0; freq1 = 32'd0; freq2 = 32'd0; freq3 = 32'd0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk_in);
        #1;
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_pt", {pt0, pt1, pt2, pt3}, 128'd0);
        reset = 1'b0;

        // Directed frames
        step(1'b1, c(4, 0), c(4, 0), c(4, 0), c(4, 0));              idle(6);
        step(1'b1, c(0, 0), c(4, 0), c(0, 0), c(0, 0));              idle(6);
        step(1'b1, c(2, 0), c(0, 0), c(0, 0), c(0, 0));              idle(6);
        step(1'b1, c(-2, 0), c(0, 0), c(0, 0), c(0, 0));             idle(6);
        step(1'b1, c(32767, 0), c(0, -32768), c(-32768, 0), c(0, 32767)); idle(6);
        step(1'b1, c(-32768, -32768), c(-32768, -32768), c(-32768, -32768), c(-32768, -32768)); idle(6);
        step(1'b1, c(32767, 32767), c(32767, 32767), c(32767, 32767), c(32767, 32767)); idle(6);

        // new_f held high with changing inputs: one frame per 6 cycles
        for (int i = 0; i < 20; i++) step(1'b1, rbin(), rbin(), rbin(), rbin());
        idle(6);

        // Second pulse two cycles after the first must be ignored
        step(1'b1, rbin(), rbin(), rbin(), rbin());
        step(1'b0, rbin(), rbin(), rbin(), rbin());
        step(1'b1, rbin(), rbin(), rbin(), rbin());
        idle(6);

        // Reset while in S2A aborts the frame
        step(1'b1, c(100, -50), c(7, 9), c(-300, 1), c(12, 12));
        idle(3);
        reset = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_pt", {pt0, pt1, pt2, pt3}, 128'd0);
        void'(q.pop_back());
        last_acc = -100;
        @(negedge clk_in);
        #1;
        reset = 1'b0;
        step(1'b1, c(40, 8), c(-4, 4), c(0, 12), c(16, -16)); idle(6);

        // Random frames with random gaps
        for (int i = 0; i < 40; i++) begin
            step(1'b1, rbin(), rbin(), rbin(), rbin());
            idle($urandom_range(0, 7));
        end

        idle(8);
        check("queue_drained", 128'(q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
